// File: rtl/bmp_frame_parser.sv
// BMP stream framer: forwards bytes through a single output register and tags
// header/pixel bytes, last pixel byte, signature errors and completed frames.
module bmp_frame_parser #(
    parameter int HDR_BYTES = 54,
    parameter int IMG_W     = 512,
    parameter int IMG_H     = 512,
    parameter int BPP_BYTES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic        sig_err,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam int PIX_BYTES   = IMG_W * IMG_H * BPP_BYTES;
    localparam int FRAME_BYTES = HDR_BYTES + PIX_BYTES;
    localparam int CNT_W       = $clog2(FRAME_BYTES);

    typedef enum logic {HDR, PIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               run;
    logic               in_acc, out_acc, hdr_end, last_byte, bad_sig;

    // run keeps the input closed until the first edge out of reset
    assign s_tready  = run && (!m_tvalid || m_tready);
    assign in_acc    = s_tvalid && s_tready;
    assign out_acc   = m_tvalid && m_tready;
    assign hdr_end   = (cnt == CNT_W'(HDR_BYTES - 1));
    assign last_byte = (cnt == CNT_W'(FRAME_BYTES - 1));
    assign bad_sig   = ((cnt == CNT_W'(0)) && (s_tdata != 8'h42)) ||
                       ((cnt == CNT_W'(1)) && (s_tdata != 8'h4D));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= HDR;
            cnt        <= '0;
            run        <= 1'b0;
            m_tdata    <= 8'h00;
            m_tvalid   <= 1'b0;
            m_tuser    <= 1'b0;
            m_tlast    <= 1'b0;
            sig_err    <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
        end else begin
            run        <= 1'b1;
            frame_done <= out_acc && m_tlast;
            if (out_acc && m_tlast)
                frame_cnt <= frame_cnt + 16'd1;

            if (in_acc) begin
                m_tdata  <= s_tdata;
                m_tvalid <= 1'b1;
                m_tuser  <= (state == HDR);
                m_tlast  <= (state == PIX) && last_byte;
                case (state)
                    HDR: begin
                        if (bad_sig)
                            sig_err <= 1'b1;
                        cnt <= cnt + 1'b1;
                        if (hdr_end)
                            state <= PIX;
                    end
                    PIX: begin
                        if (last_byte) begin
                            cnt   <= '0;
                            state <= HDR;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= HDR;
                endcase
            end else if (out_acc) begin
                m_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bmp_frame_parser.sv
// Bench for bmp_frame_parser on a 4x2x3 image: queue-based reference model
// of the byte stream, tags, signature flag and frame counting.
module tb_bmp_frame_parser;
    localparam int HDR   = 54;
    localparam int FRAME = 78;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tuser, m_tlast, sig_err, frame_done;
    logic [15:0] frame_cnt;

    bmp_frame_parser #(.HDR_BYTES(54), .IMG_W(4), .IMG_H(2), .BPP_BYTES(3)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tuser(m_tuser), .m_tlast(m_tlast),
        .sig_err(sig_err), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       user;
        logic       last;
    } beat_t;

    beat_t      q[$];
    int         pos = 0;
    logic       run_m = 1'b0, sig_m = 1'b0, fd_m = 1'b0;
    int         fc_m = 0;
    int         passed = 0, total = 0;
    logic [3:0] pat = 4'b1001;
    int         cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: drive at negedge, check outputs against the model, advance the model at posedge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic rs,
                        output logic acc);
        logic exp_rdy, oacc;
        @(negedge clk);
        s_tvalid = v; s_tdata = d; m_tready = r; rst = rs;
        #1;
        exp_rdy = run_m && (q.size() == 0 || r);
        chk("s_tready", {31'b0, s_tready}, {31'b0, exp_rdy});
        chk("m_tvalid", {31'b0, m_tvalid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("m_tdata", {24'b0, m_tdata}, {24'b0, q[0].data});
            chk("m_tuser", {31'b0, m_tuser}, {31'b0, q[0].user});
            chk("m_tlast", {31'b0, m_tlast}, {31'b0, q[0].last});
        end
        chk("sig_err", {31'b0, sig_err}, {31'b0, sig_m});
        chk("frame_done", {31'b0, frame_done}, {31'b0, fd_m});
        chk("frame_cnt", {16'b0, frame_cnt}, fc_m[15:0]);
        acc  = v && exp_rdy && rs;
        oacc = (q.size() != 0) && r;
        @(posedge clk);
        if (!rs) begin
            q.delete(); pos = 0; sig_m = 1'b0; fc_m = 0; fd_m = 1'b0; run_m = 1'b0;
        end else begin
            run_m = 1'b1;
            fd_m  = oacc && q[0].last;
            if (fd_m) fc_m = (fc_m + 1) & 16'hFFFF;
            if (oacc) void'(q.pop_front());
            if (acc) begin
                q.push_back('{data: d, user: (pos < HDR), last: (pos == FRAME - 1)});
                if ((pos == 0 && d != 8'h42) || (pos == 1 && d != 8'h4D)) sig_m = 1'b1;
                pos = (pos == FRAME - 1) ? 0 : pos + 1;
            end
        end
    endtask

    // Sends n bytes of a frame; mode 1 adds random gaps and a 1,0,0,1 ready pattern.
    task automatic send(input logic [7:0] b0, input int mode, input int n);
        int   i = 0, budget = 2000;
        logic a, v, r;
        logic [7:0] d;
        while (i < n && budget > 0) begin
            d = (i == 0) ? b0 : (i == 1) ? 8'h4D : (mode == 0) ? 8'(i) : 8'($urandom);
            v = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            r = (mode == 0) ? 1'b1 : pat[cyc % 4];
            step(v, d, r, 1'b1, a);
            if (a) i++;
            cyc++; budget--;
        end
        if (budget == 0) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int   budget = 50;
        logic a;
        while ((q.size() != 0 || fd_m) && budget > 0) begin
            step(1'b0, 8'h00, 1'b1, 1'b1, a);
            budget--;
        end
        step(1'b0, 8'h00, 1'b1, 1'b1, a);
        if (budget == 0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input int n);
        logic a;
        for (int k = 0; k < n; k++) step(1'b1, 8'h42, 1'b1, 1'b0, a);
    endtask

    initial begin
        logic a;
        // 1: reset with s_tvalid held high
        do_reset(3);
        step(1'b0, 8'h00, 1'b1, 1'b1, a);
        chk("rst_m_tdata", {24'b0, m_tdata}, 32'h0);
        chk("rst_m_tuser", {31'b0, m_tuser}, 32'h0);
        chk("rst_m_tlast", {31'b0, m_tlast}, 32'h0);
        chk("rst_frame_cnt", {16'b0, frame_cnt}, 32'h0);

        // 2: clean frame at full rate
        send(8'h42, 0, FRAME);
        drain();
        chk("t2_frame_cnt", {16'b0, frame_cnt}, 32'd1);
        chk("t2_sig_err", {31'b0, sig_err}, 32'd0);

        // 3: backpressure and gaps
        send(8'h42, 1, FRAME);
        drain();
        chk("t3_frame_cnt", {16'b0, frame_cnt}, 32'd2);

        // 4: bad signature then good frame; flag stays set
        send(8'h00, 1, FRAME);
        send(8'h42, 0, FRAME);
        drain();
        chk("t4_sig_err", {31'b0, sig_err}, 32'd1);
        chk("t4_frame_cnt", {16'b0, frame_cnt}, 32'd4);

        // 5: back-to-back frames from a fresh reset
        do_reset(1);
        send(8'h42, 0, FRAME);
        send(8'h42, 0, FRAME);
        drain();
        chk("t5_frame_cnt", {16'b0, frame_cnt}, 32'd2);
        chk("t5_sig_err", {31'b0, sig_err}, 32'd0);

        // 6: reset after byte 60, then full frame
        send(8'h42, 1, 61);
        do_reset(1);
        send(8'h42, 0, FRAME);
        drain();
        chk("t6_frame_cnt", {16'b0, frame_cnt}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
